ats21_cmd_rx: RTL and testbench
===============================

ATS21_CMD_RX -- requirements
Module: ats21_cmd_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; reset  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have the input ports: req  in  1  one-cycle instruction request; ctrlA  in  16  client A word; ctrlB  in  16  client B word.
REQ-003 The block SHALL have the output port ready  out  1  high only in IDLE (new req accepted).
REQ-004 The block SHALL have the output port stat  out  2  rejection flags, bit1 = A rejected, bit0 = B rejected, valid in the RESP-output cycle.
REQ-005 The block SHALL have, per client x in {a, b}, the outputs: x_valid 1 (accepted non-NOP command pulse); x_op 3; x_id 5 (clock # zero-extended, or alarm/timer #); x_clk 4 (clock # of an alarm/timer); x_rate 2; x_flag 1 (enable or repeat); x_val 16 (alarm time or interval).
REQ-006 The block SHALL have the outputs: mode_active  out  1; mode_allow_t  out  2  (bit1 = A, bit0 = B); mode_allow_c  out  2  (bit1 = A, bit0 = B).

Function
REQ-007 The FSM SHALL have states IDLE, HI, LO and RESP; IDLE->HI on req=1 sampled at edge N; HI->LO at N+1, capturing ctrlA/ctrlB as the high words; LO->RESP at N+2, capturing the low words; RESP->IDLE at N+3, registering all decode outputs.
REQ-008 x_valid, stat and the x_* fields SHALL be valid for exactly the one cycle following edge N+3, with stat=00 and x_valid=0 at all other times; the fields SHALL hold their last value.
REQ-009 req SHALL be ignored in HI, LO and RESP.
REQ-010 Opcodes SHALL be decoded from high word [15:13]: 000 NOP, 001 set clock, 010 enable clock, 011 set mode, 101 set alarm, 110 set timer, 111 enable alarm/timer; fields are as follows.
REQ-011 Field extraction SHALL be: clock # from hi[12:9], rate from hi[7:6], clock enable from hi[7], alarm # from hi[12:8], repeat/enable from hi[7], alarm clock # from hi[3:0], value from lo[15:0]; unused bits are ignored.
REQ-012 NOP SHALL give x_valid=0 with the stat bit at 0.
REQ-013 Opcode 100 SHALL be rejected as illegal.
REQ-014 Set mode (011) SHALL always be accepted and SHALL update mode_active=hi[12], mode_allow_t=hi[11:10] and mode_allow_c=hi[9:8] at edge N+3.
REQ-015 If both clients send set mode in the same instruction, A SHALL win and B SHALL be rejected.
REQ-016 Clock ops (001/010) from client x SHALL be rejected when mode_active=0 or the client's allow_c bit is 0; alarm/timer ops (101/110/111) SHALL be rejected when mode_active=0 or the client's allow_t bit is 0.
REQ-017 Gating SHALL use the mode value held before the current instruction.
REQ-018 If A and B both issue accepted clock ops on the same clock #, or both issue accepted alarm/timer ops on the same alarm #, A SHALL be accepted and B rejected (conflict).
REQ-019 A rejected command SHALL set its stat bit to 1 and give x_valid=0.

Reset
REQ-020 When reset=0, the block SHALL immediately enter IDLE with ready=1, stat=00, x_valid=0, all x_* fields 0, mode_active=1, mode_allow_t=11 and mode_allow_c=11.
REQ-021 Reset in HI, LO or RESP SHALL discard the partial instruction with no output pulse.
REQ-022 The first req SHALL be sampled no earlier than the first edge after reset deasserts.

Structure
REQ-023 Package ats21_pkg SHALL hold the opcode enum, the FSM state enum and the decoded-command struct (op, id, clk, rate, flag, val).
REQ-024 One combinational sub-module, ats21_word_decode, SHALL map {hi, lo} to the decoded struct plus an illegal flag, instantiated once per client.
REQ-025 Gating, conflict resolution and mode storage SHALL reside in ats21_cmd_rx.

Verification
REQ-026 Reset: hold reset=0 for 4 cycles -> ready=1, stat=00, valids=0, mode=1/11/11.
REQ-027 Set-clock pair: A hi=2000 lo=0000 and B hi=2240 lo=0000 -> a_valid=b_valid=1 one cycle after N+3; a_id=0, a_rate=00; b_id=1, b_rate=01; stat=00; ready low from N+1 to N+3.
REQ-028 Conflict: A=B hi=2400 -> a_valid=1, b_valid=0, stat=01.
REQ-029 Mode gating: A sets mode with hi=7800 (timer change for A only); next, A and B both send hi=A583 lo=1234 -> B rejected (stat=01); a_valid=1, a_id=5, a_flag=1, a_clk=3, a_val=1234.
REQ-030 Illegal/NOP: A hi=8000 and B hi=0000 -> stat=10, no valids.
REQ-031 Reset mid-op: assert reset in LO -> no valid pulse, FSM in IDLE, mode restored to defaults.

Source files
------------

// File: rtl/ats21_pkg.sv
// Shared types for the two-client ATS21 command receiver: opcodes, FSM states,
// the decoded-command record and the per-client accept/reject helper.
package ats21_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'b000,
    OP_SET_CLK  = 3'b001,
    OP_EN_CLK   = 3'b010,
    OP_SET_MODE = 3'b011,
    OP_ILLEGAL  = 3'b100,
    OP_SET_ALM  = 3'b101,
    OP_SET_TMR  = 3'b110,
    OP_EN_ALM   = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef struct packed {
    opcode_t     op;
    logic [4:0]  id;
    logic [3:0]  clk;
    logic [1:0]  rate;
    logic        flag;
    logic [15:0] val;
  } cmd_t;

  function automatic logic is_clk_op(opcode_t op);
    return (op == OP_SET_CLK) || (op == OP_EN_CLK);
  endfunction

  function automatic logic is_tmr_op(opcode_t op);
    return (op == OP_SET_ALM) || (op == OP_SET_TMR) || (op == OP_EN_ALM);
  endfunction

  // Returns {accept, reject} for one client before any A/B conflict is applied.
  function automatic logic [1:0] gate_cmd(opcode_t op, logic active,
                                          logic allow_t, logic allow_c);
    logic [1:0] res;
    res = 2'b00;
    if (op == OP_ILLEGAL)                  res = 2'b01;
    else if (op == OP_SET_MODE)            res = 2'b10;
    else if (is_clk_op(op))                res = (active && allow_c) ? 2'b10 : 2'b01;
    else if (is_tmr_op(op))                res = (active && allow_t) ? 2'b10 : 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/ats21_word_decode.sv
// Combinational decode of one client's {hi, lo} word pair into a cmd_t record.
module ats21_word_decode
  import ats21_pkg::*;
(
  input  logic [15:0] hi,
  input  logic [15:0] lo,
  output cmd_t        cmd,
  output logic        illegal
);

  logic unused_bits;
  assign unused_bits = ^hi[5:4];

  always_comb begin
    cmd     = '0;
    cmd.op  = opcode_t'(hi[15:13]);
    illegal = (cmd.op == OP_ILLEGAL);
    case (cmd.op)
      OP_SET_CLK: begin
        cmd.id   = {1'b0, hi[12:9]};
        cmd.rate = hi[7:6];
      end
      OP_EN_CLK: begin
        cmd.id   = {1'b0, hi[12:9]};
        cmd.flag = hi[7];
      end
      OP_SET_ALM, OP_SET_TMR: begin
        cmd.id   = hi[12:8];
        cmd.clk  = hi[3:0];
        cmd.flag = hi[7];
        cmd.val  = lo;
      end
      OP_EN_ALM: begin
        cmd.id   = hi[12:8];
        cmd.clk  = hi[3:0];
        cmd.flag = hi[7];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ats21_cmd_rx.sv
// Two-client command receiver: collects hi/lo words over two cycles, then gates
// each client against the stored mode, resolves A/B conflicts and pulses results.
module ats21_cmd_rx
  import ats21_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic        a_valid,
  output logic [2:0]  a_op,
  output logic [4:0]  a_id,
  output logic [3:0]  a_clk,
  output logic [1:0]  a_rate,
  output logic        a_flag,
  output logic [15:0] a_val,
  output logic        b_valid,
  output logic [2:0]  b_op,
  output logic [4:0]  b_id,
  output logic [3:0]  b_clk,
  output logic [1:0]  b_rate,
  output logic        b_flag,
  output logic [15:0] b_val,
  output logic        mode_active,
  output logic [1:0]  mode_allow_t,
  output logic [1:0]  mode_allow_c,
  output logic [1:0]  dbg_state
);

  state_t      state_q, state_d;
  logic [15:0] hi_a, hi_b, lo_a, lo_b;
  cmd_t        dec_a, dec_b, out_a, out_b;
  logic        ill_a, ill_b;
  logic        acc_a, rej_a, acc_b, rej_b, conflict;

  ats21_word_decode u_dec_a (.hi(hi_a), .lo(lo_a), .cmd(dec_a), .illegal(ill_a));
  ats21_word_decode u_dec_b (.hi(hi_b), .lo(lo_b), .cmd(dec_b), .illegal(ill_b));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_HI;
      ST_HI:   state_d = ST_LO;
      ST_LO:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready     = (state_q == ST_IDLE);
  assign dbg_state = state_q;

  // Gating uses the mode registers, which only change at the RESP edge, so the
  // values seen here are always those held before the current instruction.
  always_comb begin
    {acc_a, rej_a} = gate_cmd(dec_a.op, mode_active, mode_allow_t[1], mode_allow_c[1]);
    {acc_b, rej_b} = gate_cmd(dec_b.op, mode_active, mode_allow_t[0], mode_allow_c[0]);
    conflict = acc_a && acc_b &&
               ((dec_a.op == OP_SET_MODE && dec_b.op == OP_SET_MODE) ||
                (is_clk_op(dec_a.op) && is_clk_op(dec_b.op) && dec_a.id == dec_b.id) ||
                (is_tmr_op(dec_a.op) && is_tmr_op(dec_b.op) && dec_a.id == dec_b.id));
    if (conflict) begin
      acc_b = 1'b0;
      rej_b = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_a         <= '0;
      hi_b         <= '0;
      lo_a         <= '0;
      lo_b         <= '0;
      a_valid      <= 1'b0;
      b_valid      <= 1'b0;
      stat         <= 2'b00;
      out_a        <= '0;
      out_b        <= '0;
      mode_active  <= 1'b1;
      mode_allow_t <= 2'b11;
      mode_allow_c <= 2'b11;
    end else begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      stat    <= 2'b00;
      if (state_q == ST_HI) begin
        hi_a <= ctrlA;
        hi_b <= ctrlB;
      end
      if (state_q == ST_LO) begin
        lo_a <= ctrlA;
        lo_b <= ctrlB;
      end
      if (state_q == ST_RESP) begin
        a_valid <= acc_a;
        b_valid <= acc_b;
        stat    <= {rej_a, rej_b};
        if (acc_a) out_a <= dec_a;
        if (acc_b) out_b <= dec_b;
        if (acc_a && dec_a.op == OP_SET_MODE) begin
          mode_active  <= hi_a[12];
          mode_allow_t <= hi_a[11:10];
          mode_allow_c <= hi_a[9:8];
        end else if (acc_b && dec_b.op == OP_SET_MODE) begin
          mode_active  <= hi_b[12];
          mode_allow_t <= hi_b[11:10];
          mode_allow_c <= hi_b[9:8];
        end
      end
    end
  end

  assign a_op   = out_a.op;
  assign a_id   = out_a.id;
  assign a_clk  = out_a.clk;
  assign a_rate = out_a.rate;
  assign a_flag = out_a.flag;
  assign a_val  = out_a.val;
  assign b_op   = out_b.op;
  assign b_id   = out_b.id;
  assign b_clk  = out_b.clk;
  assign b_rate = out_b.rate;
  assign b_flag = out_b.flag;
  assign b_val  = out_b.val;

endmodule

// File: tb/tb_ats21_cmd_rx.sv
// Directed bench for ats21_cmd_rx: hand-computed vectors for reset, set-clock,
// conflict, mode gating, illegal/NOP and reset in the middle of an instruction.
module tb_ats21_cmd_rx;

  logic        clk, reset, req;
  logic [15:0] ctrlA, ctrlB;
  logic        ready;
  logic [1:0]  stat;
  logic        a_valid, b_valid, a_flag, b_flag;
  logic [2:0]  a_op, b_op;
  logic [4:0]  a_id, b_id;
  logic [3:0]  a_clk, b_clk;
  logic [1:0]  a_rate, b_rate;
  logic [15:0] a_val, b_val;
  logic        mode_active;
  logic [1:0]  mode_allow_t, mode_allow_c, dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  ats21_cmd_rx dut (
    .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready), .stat(stat),
    .a_valid(a_valid), .a_op(a_op), .a_id(a_id), .a_clk(a_clk),
    .a_rate(a_rate), .a_flag(a_flag), .a_val(a_val),
    .b_valid(b_valid), .b_op(b_op), .b_id(b_id), .b_clk(b_clk),
    .b_rate(b_rate), .b_flag(b_flag), .b_val(b_val),
    .mode_active(mode_active), .mode_allow_t(mode_allow_t),
    .mode_allow_c(mode_allow_c), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction; returns #1 after edge N+3, where results are visible.
  task automatic send(input logic [15:0] a_hi, input logic [15:0] a_lo,
                      input logic [15:0] b_hi, input logic [15:0] b_lo);
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req   = 1'b0;
    ctrlA = a_hi;
    ctrlB = b_hi;
    chk("ready_hi", ready, 0);
    @(posedge clk);
    #1;
    ctrlA = a_lo;
    ctrlB = b_lo;
    @(posedge clk);
    #1;
    chk("ready_resp", ready, 0);
    chk("stat_idle", stat, 0);
    @(posedge clk);
    #1;
    chk("ready_back", ready, 1);
  endtask

  initial begin
    reset = 1'b0;
    req   = 1'b0;
    ctrlA = '0;
    ctrlB = '0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_stat", stat, 0);
    chk("rst_valids", {a_valid, b_valid}, 0);
    chk("rst_mode", {mode_active, mode_allow_t, mode_allow_c}, 5'b1_11_11);
    chk("rst_state", dbg_state, 0);
    chk("rst_a_id", a_id, 0);
    @(negedge clk);
    reset = 1'b1;

    // Set-clock pair: A clock 0 rate 0, B clock 1 rate 1
    send(16'h2000, 16'h0000, 16'h2240, 16'h0000);
    chk("sc_valids", {a_valid, b_valid}, 2'b11);
    chk("sc_stat", stat, 0);
    chk("sc_a_op", a_op, 1);
    chk("sc_a_id", a_id, 0);
    chk("sc_a_rate", a_rate, 0);
    chk("sc_b_id", b_id, 1);
    chk("sc_b_rate", b_rate, 1);
    @(posedge clk);
    #1;
    chk("sc_pulse_end", {a_valid, b_valid, stat}, 0);
    chk("sc_b_id_hold", b_id, 1);

    // Conflict on clock 2
    send(16'h2400, 16'h0000, 16'h2400, 16'h0000);
    chk("cf_valids", {a_valid, b_valid}, 2'b10);
    chk("cf_stat", stat, 2'b01);
    chk("cf_a_id", a_id, 2);
    chk("cf_b_id_hold", b_id, 1);

    // A sets mode: active=1, allow_t=10, allow_c=00
    send(16'h7800, 16'h0000, 16'h0000, 16'h0000);
    chk("sm_valids", {a_valid, b_valid}, 2'b10);
    chk("sm_a_op", a_op, 3);
    chk("sm_stat", stat, 0);
    chk("sm_mode", {mode_active, mode_allow_t, mode_allow_c}, 5'b1_10_00);

    // Set alarm 5 on clock 3, repeat: B lacks timer permission
    send(16'hA583, 16'h1234, 16'hA583, 16'h1234);
    chk("al_stat", stat, 2'b01);
    chk("al_valids", {a_valid, b_valid}, 2'b10);
    chk("al_a_op", a_op, 5);
    chk("al_a_id", a_id, 5);
    chk("al_a_flag", a_flag, 1);
    chk("al_a_clk", a_clk, 3);
    chk("al_a_val", a_val, 16'h1234);
    chk("al_b_id_hold", b_id, 1);

    // Clock ops now barred for both clients
    send(16'h2000, 16'h0000, 16'h2240, 16'h0000);
    chk("cg_stat", stat, 2'b11);
    chk("cg_valids", {a_valid, b_valid}, 0);

    // Illegal opcode on A, NOP on B
    send(16'h8000, 16'h0000, 16'h0000, 16'h0000);
    chk("il_stat", stat, 2'b10);
    chk("il_valids", {a_valid, b_valid}, 0);

    // Reset while in LO
    @(negedge clk);
    req = 1'b1;
    @(posedge clk);
    #1;
    req   = 1'b0;
    ctrlA = 16'h2000;
    ctrlB = 16'h0000;
    @(posedge clk);
    #1;
    chk("mr_in_lo", dbg_state, 2);
    reset = 1'b0;
    #1;
    chk("mr_state", dbg_state, 0);
    chk("mr_ready", ready, 1);
    chk("mr_mode", {mode_active, mode_allow_t, mode_allow_c}, 5'b1_11_11);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_no_pulse", {a_valid, b_valid, stat}, 0);
    chk("mr_a_id_clr", a_id, 0);

    // Clock op accepted again with default mode
    send(16'h2000, 16'h0000, 16'h0000, 16'h0000);
    chk("pr_valids", {a_valid, b_valid}, 2'b10);
    chk("pr_stat", stat, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
